// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result FIFOs drained one result per cycle onto the CDB in round-robin order.
// Optional CDB_PERF_CNT_EN adds perf_stall_cnt, a saturating count of cycles in which a result waited.
module cdb_arbiter #(
  parameter int unsigned NUM_FU     = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PHY_WIDTH  = 6,
  parameter int unsigned ROB_WIDTH  = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               fu_valid,
  output logic [NUM_FU-1:0]               fu_ready,
  input  logic [NUM_FU*PHY_WIDTH-1:0]     fu_phy_rd,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_data,
  input  logic [NUM_FU*ROB_WIDTH-1:0]     fu_rob_idx,
  output logic                            cdb_valid,
  output logic [PHY_WIDTH-1:0]            cdb_phy_rd,
  output logic [DATA_WIDTH-1:0]           cdb_data,
  output logic [ROB_WIDTH-1:0]            cdb_rob_idx,
  output logic [$clog2(NUM_FU)-1:0]       cdb_fu_id
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_stall_cnt
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_FU);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = PHY_WIDTH + DATA_WIDTH + ROB_WIDTH;

  logic [NUM_FU-1:0][FIFO_DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
  logic [NUM_FU-1:0][PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [NUM_FU-1:0][PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [NUM_FU-1:0][CNT_W-1:0]                 count_q, count_d;
  logic [NUM_FU-1:0]                            ready_q, ready_d;
  logic [ID_W-1:0]                              rr_ptr_q, rr_ptr_d;
  logic                                         cdb_valid_q, cdb_valid_d;
  logic [ENT_W-1:0]                             cdb_ent_q, cdb_ent_d;
  logic [ID_W-1:0]                              cdb_fu_id_q, cdb_fu_id_d;

  logic [NUM_FU-1:0]                            nonempty_c;
  logic                                         grant_vld_c;
  logic [ID_W-1:0]                              grant_id_c;
  logic [ENT_W-1:0]                             head_c;

  always_comb begin
    nonempty_c = '0;
    for (int i = 0; i < int'(NUM_FU); i++) begin
      nonempty_c[i] = (count_q[i] != '0);
    end
  end

  // Round-robin scan: first non-empty FIFO at or above rr_ptr, wrapping modulo NUM_FU.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_vld_c = 1'b0;
    grant_id_c  = '0;
    for (int k = 0; k < int'(NUM_FU); k++) begin
      idx = (32'(rr_ptr_q) + 32'(k)) % NUM_FU;
      if (!grant_vld_c && nonempty_c[ID_W'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = ID_W'(idx);
      end
    end
  end

  assign head_c = mem_q[grant_id_c][rd_ptr_q[grant_id_c]];

  always_comb begin
    logic push;
    logic pop;
    push        = 1'b0;
    pop         = 1'b0;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_ent_d   = cdb_ent_q;
    cdb_fu_id_d = cdb_fu_id_q;
    ready_d     = '0;

    for (int i = 0; i < int'(NUM_FU); i++) begin
      push = fu_valid[i] && ready_q[i];
      pop  = grant_vld_c && (grant_id_c == ID_W'(i));
      if (push) begin
        mem_d[i][wr_ptr_q[i]] = {fu_phy_rd[i*PHY_WIDTH +: PHY_WIDTH],
                                 fu_data[i*DATA_WIDTH +: DATA_WIDTH],
                                 fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH]};
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else if (!push && pop) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
    end

    if (grant_vld_c) begin
      cdb_valid_d = 1'b1;
      cdb_ent_d   = head_c;
      cdb_fu_id_d = grant_id_c;
      rr_ptr_d    = (grant_id_c == ID_W'(NUM_FU - 1)) ? '0 : grant_id_c + ID_W'(1);
    end

    // Flush squashes everything, including pushes presented this cycle.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rr_ptr_d    = '0;
      cdb_valid_d = 1'b0;
    end

    for (int i = 0; i < int'(NUM_FU); i++) begin
      ready_d[i] = (count_d[i] != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= '1;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_ent_q   <= '0;
      cdb_fu_id_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_ent_q   <= cdb_ent_d;
      cdb_fu_id_q <= cdb_fu_id_d;
    end
  end

  assign fu_ready                              = ready_q;
  assign cdb_valid                             = cdb_valid_q;
  assign {cdb_phy_rd, cdb_data, cdb_rob_idx}   = cdb_ent_q;
  assign cdb_fu_id                             = cdb_fu_id_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  logic        stall_c;

  // A stall is a buffered result passed over, or a unit held off by a full FIFO.
  always_comb begin
    stall_c = |(fu_valid & ~ready_q);
    for (int i = 0; i < int'(NUM_FU); i++) begin
      if (nonempty_c[i] && !(grant_vld_c && (grant_id_c == ID_W'(i)))) begin
        stall_c = 1'b1;
      end
    end
    perf_d = perf_q;
    if (flush) begin
      perf_d = '0;
    end else if (stall_c && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule
